alu_ctrl_seq: RTL and testbench
===============================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CTRL_W, 5, alu_ctrl width (>=5).
- M_EN, 1, enables RV32M decode.
- MUL_LAT, 2, accept-to-out_valid cycles for MUL group (>=2).
- DIV_LAT, 33, accept-to-out_valid cycles for DIV/REM group (>=2).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-low reset.
- flush, in, 1, synchronous kill of in-flight op.
- in_valid, in, 1, decode request.
- in_ready, out, 1, request accepted when high with in_valid.
- alu_op, in, 2, 00 load/store, 01 branch, 10 R-type, 11 I-type.
- funct3, in, 3, instruction funct3.
- funct7_5, in, 1, instr[30].
- funct7_0, in, 1, instr[25] (M-extension select).
- op4, in, 1, opcode bit 4.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts the result.
- alu_ctrl, out, CTRL_W, decoded control code.
- illegal, out, 1, unsupported encoding.
- multicycle, out, 1, result came from a MUL/DIV-group op.
- busy, out, 1, state==EXEC.
- mc_start, out, 1, one-cycle start pulse to the mul/div unit.
- mc_abort, out, 1, one-cycle abort pulse to the mul/div unit.

Function
REQ-003 Codes (zero-extended to CTRL_W) SHALL be:
- ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111
- BLT 1000, BGE 1001, BLTU 1010, BGEU 1011, BEQ 1100, BNE 1101, SRA 1110, SLTU 1111
- MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111

REQ-004 alu_op=00 SHALL decode to ADD.

REQ-005 alu_op=01 SHALL decode funct3 as follows:
- 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- 010 and 011 are illegal.

REQ-006 alu_op=10 with funct7_0=0 SHALL decode funct3 as follows:
- 000 ADD or SUB (funct7_5=1 gives SUB).
- 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
- 101 SRL or SRA (funct7_5=1 gives SRA).
- 110 OR, 111 AND.

REQ-007 alu_op=10 with funct7_0=1 and M_EN=1 SHALL decode to code 10000 + funct3 (MUL..REMU).

REQ-008 alu_op=10 with funct7_0=1 and M_EN=0 SHALL be illegal.

REQ-009 alu_op=11 SHALL decode funct3 as follows:
- 000 ADD.
- 010 SLT when op4=1, ADD when op4=0.
- 011 SLTU, 100 XOR, 110 OR, 111 AND, 001 SLL.
- 101 SRL or SRA (funct7_5=1 gives SRA).

REQ-010 An illegal encoding SHALL produce alu_ctrl=ADD and illegal=1, and SHALL be treated as single-cycle; no X shall ever be driven.

REQ-011 The FSM SHALL have exactly two states, IDLE and EXEC.

REQ-012 The output register SHALL hold alu_ctrl, illegal, multicycle and a valid flag (out_valid).

REQ-013 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !flush.

REQ-014 Accepting a single-cycle op in cycle T SHALL load the output register and assert out_valid in cycle T+1.

REQ-015 Accepting a MUL-group (funct3 0xx) or DIV-group (funct3 1xx) op in cycle T SHALL:
- load alu_ctrl and set multicycle=1;
- clear out_valid;
- enter EXEC;
- pulse mc_start in T+1 only;
- assert out_valid in exactly T+LAT (LAT = MUL_LAT or DIV_LAT) and return to IDLE.

REQ-016 The latency counter SHALL be sized $clog2(max(MUL_LAT,DIV_LAT)+1) and SHALL never wrap or underflow.

REQ-017 While out_valid=1 and out_ready=0, alu_ctrl, illegal and multicycle SHALL stay stable.

REQ-018 out_valid && out_ready in IDLE with no new accept SHALL clear out_valid the next cycle.

REQ-019 A simultaneous consume and accept SHALL load the new op with no bubble.

REQ-020 Flush SHALL:
- clear out_valid;
- force IDLE and clear the counter;
- suppress any pending mc_start;
- pulse mc_abort for one cycle if the state was EXEC.

REQ-021 Flush during an accept cycle SHALL drop the incoming request (in_ready is 0).

Reset
REQ-022 On a clk edge with rst=0 the block SHALL set state=IDLE, counter=0, out_valid=0, alu_ctrl=0, illegal=0, multicycle=0, mc_start=0, mc_abort=0; busy=0.

REQ-023 Reset SHALL override flush and any in-flight op without pulsing mc_abort.

REQ-024 in_ready SHALL be 0 while rst=0 and SHALL be 1 the first cycle after rst is released.

Verification
REQ-025 alu_op=10, funct3=101, funct7_5=1, funct7_0=0, accepted in T -> alu_ctrl=01110, out_valid=1 in T+1, illegal=0.

REQ-026 alu_op=10, funct7_0=1, funct3=100 (DIV), DIV_LAT=33, accepted in T:
- mc_start=1 in T+1 only;
- busy=1 from T+1 to T+32;
- out_valid=1 in T+33 with alu_ctrl=10100 and multicycle=1.

REQ-027 MUL accepted in T, flush in T+1 -> mc_abort=1 in T+2, out_valid stays 0, in_ready=1 in T+2.

REQ-028 alu_op=01, funct3=010 -> illegal=1, alu_ctrl=00000; with M_EN=0, alu_op=10, funct7_0=1 -> illegal=1.

REQ-029 Back-pressure case:
- out_valid=1 with out_ready=0 for 4 cycles -> in_ready=0 and outputs unchanged;
- out_ready=1 with in_valid=1 (alu_op=11, funct3=111) -> next cycle alu_ctrl=00010, out_valid=1.

REQ-030 rst=0 asserted mid-EXEC -> next cycle busy=0, out_valid=0, mc_abort=0, and all outputs at their reset values.

Source files
------------

// File: rtl/alu_ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq_if
// Bundle of the decode-request / result handshake and the mul/div control
// strobes used by alu_ctrl_seq.
//
// Signals (direction seen from the decoder, i.e. the slave modport):
//   flush       in   kill any in-flight op
//   in_valid    in   decode request
//   in_ready    out  request accepted when high together with in_valid
//   alu_op      in   00 load/store, 01 branch, 10 R-type, 11 I-type
//   funct3      in   instruction funct3
//   funct7_5    in   instr[30]
//   funct7_0    in   instr[25] (M-extension select)
//   op4         in   opcode bit 4
//   out_valid   out  result valid
//   out_ready   in   consumer accepts the result
//   alu_ctrl    out  decoded control code (CTRL_W bits)
//   illegal     out  unsupported encoding
//   multicycle  out  result came from a MUL/DIV-group op
//   busy        out  decoder is waiting on the mul/div unit
//   mc_start    out  one-cycle start pulse to the mul/div unit
//   mc_abort    out  one-cycle abort pulse to the mul/div unit
// ---------------------------------------------------------------------------
interface alu_ctrl_seq_if #(
    parameter int CTRL_W = 5
) ();
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        alu_op;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic              funct7_0;
    logic              op4;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              illegal;
    logic              multicycle;
    logic              busy;
    logic              mc_start;
    logic              mc_abort;

    // Decoder side.
    modport slave (
        input  flush, in_valid, alu_op, funct3, funct7_5, funct7_0, op4, out_ready,
        output in_ready, out_valid, alu_ctrl, illegal, multicycle, busy, mc_start, mc_abort
    );

    // Requester / consumer side.
    modport master (
        output flush, in_valid, alu_op, funct3, funct7_5, funct7_0, op4, out_ready,
        input  in_ready, out_valid, alu_ctrl, illegal, multicycle, busy, mc_start, mc_abort
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
// Decodes RV32I/RV32M ALU control from alu_op/funct fields and sequences the
// result through a valid/ready output register. MUL/DIV-group ops park the
// block in EXEC for a fixed latency while an external unit computes.
//
// Ports:
//   clk   in   single clock
//   rst   in   synchronous active-low reset
//   bus   slave modport of alu_ctrl_seq_if (handshakes, decode fields,
//             decoded outputs, mc_start/mc_abort strobes)
// ---------------------------------------------------------------------------
module alu_ctrl_seq #(
    parameter int CTRL_W  = 5,
    parameter int M_EN    = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_ctrl_seq_if.slave        bus
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    // Counter reload values: the first EXEC cycle is already T+1.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic              illegal_q, illegal_d;
    logic              multi_q, multi_d;
    logic              mc_start_q, mc_start_d;
    logic              mc_abort_q, mc_abort_d;

    logic              in_ready_s;
    logic              busy_s;
    logic              accept_s;
    logic [6:0]        dec_s;
    logic [4:0]        dec_code_s;
    logic              dec_ill_s;
    logic              dec_mc_s;

    // Returns {illegal, multicycle, code[4:0]}; illegal encodings yield ADD.
    function automatic logic [6:0] decode(
        input logic [1:0] op,
        input logic [2:0] f3,
        input logic       f75,
        input logic       f70,
        input logic       o4
    );
        logic [4:0] code;
        logic       ill;
        logic       mc;
        code = 5'b00000;
        ill  = 1'b0;
        mc   = 1'b0;
        case (op)
            2'b00: code = 5'b00000;
            2'b01: begin
                case (f3)
                    3'b000:  code = 5'b01100;
                    3'b001:  code = 5'b01101;
                    3'b100:  code = 5'b01000;
                    3'b101:  code = 5'b01001;
                    3'b110:  code = 5'b01010;
                    3'b111:  code = 5'b01011;
                    default: ill  = 1'b1;
                endcase
            end
            2'b10: begin
                if (f70) begin
                    if (M_EN != 0) begin
                        code = {2'b10, f3};
                        mc   = 1'b1;
                    end else begin
                        ill  = 1'b1;
                    end
                end else begin
                    case (f3)
                        3'b000:  code = f75 ? 5'b00001 : 5'b00000;
                        3'b001:  code = 5'b00110;
                        3'b010:  code = 5'b00101;
                        3'b011:  code = 5'b01111;
                        3'b100:  code = 5'b00100;
                        3'b101:  code = f75 ? 5'b01110 : 5'b00111;
                        3'b110:  code = 5'b00011;
                        3'b111:  code = 5'b00010;
                        default: ill  = 1'b1;
                    endcase
                end
            end
            2'b11: begin
                case (f3)
                    3'b000:  code = 5'b00000;
                    3'b001:  code = 5'b00110;
                    // op4=0 marks a non-OP-IMM opcode sharing funct3=010: plain add
                    3'b010:  code = o4 ? 5'b00101 : 5'b00000;
                    3'b011:  code = 5'b01111;
                    3'b100:  code = 5'b00100;
                    3'b101:  code = f75 ? 5'b01110 : 5'b00111;
                    3'b110:  code = 5'b00011;
                    3'b111:  code = 5'b00010;
                    default: ill  = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        return {ill, mc, code};
    endfunction

    // Field decode of the presented request.
    always_comb begin
        dec_s      = decode(bus.alu_op, bus.funct3, bus.funct7_5, bus.funct7_0, bus.op4);
        dec_ill_s  = dec_s[6];
        dec_mc_s   = dec_s[5];
        dec_code_s = dec_s[4:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s && dec_mc_s) begin
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                // cnt<=1 rather than ==1 so a corrupted zero count cannot wedge EXEC
                if (bus.flush || (cnt_q <= CNT_ONE)) begin
                    state_d = IDLE;
                end else begin
                    state_d = EXEC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake readiness and busy indication.
    always_comb begin
        in_ready_s = rst && (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
        busy_s     = (state_q == EXEC);
        accept_s   = bus.in_valid && in_ready_s;
    end

    // Output-register, latency-counter and strobe next values.
    always_comb begin
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        alu_ctrl_d  = alu_ctrl_q;
        illegal_d   = illegal_q;
        multi_d     = multi_q;
        mc_start_d  = 1'b0;
        mc_abort_d  = 1'b0;
        if (bus.flush) begin
            out_valid_d = 1'b0;
            cnt_d       = CNT_ZERO;
            mc_abort_d  = (state_q == EXEC);
        end else if (state_q == EXEC) begin
            if (cnt_q <= CNT_ONE) begin
                out_valid_d = 1'b1;
                cnt_d       = CNT_ZERO;
            end else begin
                cnt_d       = cnt_q - CNT_ONE;
            end
        end else if (accept_s) begin
            alu_ctrl_d = CTRL_W'(dec_code_s);
            illegal_d  = dec_ill_s;
            multi_d    = dec_mc_s;
            if (dec_mc_s) begin
                out_valid_d = 1'b0;
                mc_start_d  = 1'b1;
                // funct3[2] separates the DIV/REM group from the MUL group
                cnt_d       = bus.funct3[2] ? DIV_LOAD : MUL_LOAD;
            end else begin
                out_valid_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register, latency counter and strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= CNT_ZERO;
            out_valid_q <= 1'b0;
            alu_ctrl_q  <= {CTRL_W{1'b0}};
            illegal_q   <= 1'b0;
            multi_q     <= 1'b0;
            mc_start_q  <= 1'b0;
            mc_abort_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            alu_ctrl_q  <= alu_ctrl_d;
            illegal_q   <= illegal_d;
            multi_q     <= multi_d;
            mc_start_q  <= mc_start_d;
            mc_abort_q  <= mc_abort_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.busy       = busy_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_ctrl   = alu_ctrl_q;
    assign bus.illegal    = illegal_q;
    assign bus.multicycle = multi_q;
    assign bus.mc_start   = mc_start_q;
    assign bus.mc_abort   = mc_abort_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_seq
// Scoreboard bench: directed requests push hand-computed results into a
// queue; a monitor pops and compares on every result handshake. Timing of
// strobes, flush, back-pressure and reset is checked inline.
// dut0: M_EN=1, dut1: M_EN=0.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_seq;

    typedef struct packed {
        logic [4:0] ctrl;
        logic       ill;
        logic       mc;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   last_wait;
    int   bad;
    exp_t q0[$];
    exp_t q1[$];

    alu_ctrl_seq_if #(.CTRL_W(5)) bus0 ();
    alu_ctrl_seq_if #(.CTRL_W(5)) bus1 ();

    alu_ctrl_seq #(.CTRL_W(5), .M_EN(1), .MUL_LAT(2), .DIV_LAT(33)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    alu_ctrl_seq #(.CTRL_W(5), .M_EN(0), .MUL_LAT(2), .DIV_LAT(33)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request on dut<sel>, wait (bounded) for acceptance, record expectation.
    task automatic issue(input int sel, input logic [1:0] op, input logic [2:0] f3,
                         input logic f75, input logic f70, input logic o4,
                         input logic [4:0] ec, input logic ei, input logic em, input bit push);
        int   waited;
        exp_t e;
        waited = 0;
        if (sel == 0) begin
            bus0.alu_op = op; bus0.funct3 = f3; bus0.funct7_5 = f75;
            bus0.funct7_0 = f70; bus0.op4 = o4; bus0.in_valid = 1'b1;
        end else begin
            bus1.alu_op = op; bus1.funct3 = f3; bus1.funct7_5 = f75;
            bus1.funct7_0 = f70; bus1.op4 = o4; bus1.in_valid = 1'b1;
        end
        #1;
        while (((sel == 0) ? bus0.in_ready : bus1.in_ready) !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        last_wait = waited;
        if (waited >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready within 200 cycles");
        end else begin
            e.ctrl = ec; e.ill = ei; e.mc = em;
            if (push) begin
                if (sel == 0) q0.push_back(e); else q1.push_back(e);
            end
            tick();
        end
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    // Scoreboard monitors: one comparison set per result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected: got result %0h expected none", bus0.alu_ctrl);
            end else begin
                e = q0.pop_front();
                chk("dut0_alu_ctrl", 32'(bus0.alu_ctrl), 32'(e.ctrl));
                chk("dut0_illegal", 32'(bus0.illegal), 32'(e.ill));
                chk("dut0_multicycle", 32'(bus0.multicycle), 32'(e.mc));
            end
        end
        if (bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected: got result %0h expected none", bus1.alu_ctrl);
            end else begin
                e = q1.pop_front();
                chk("dut1_alu_ctrl", 32'(bus1.alu_ctrl), 32'(e.ctrl));
                chk("dut1_illegal", 32'(bus1.illegal), 32'(e.ill));
                chk("dut1_multicycle", 32'(bus1.multicycle), 32'(e.mc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0; checks = 0; last_wait = 0; bad = 0;
        rst = 1'b0;
        bus0.flush = 1'b0; bus0.in_valid = 1'b0; bus0.alu_op = 2'b00; bus0.funct3 = 3'b000;
        bus0.funct7_5 = 1'b0; bus0.funct7_0 = 1'b0; bus0.op4 = 1'b0; bus0.out_ready = 1'b1;
        bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.alu_op = 2'b00; bus1.funct3 = 3'b000;
        bus1.funct7_5 = 1'b0; bus1.funct7_0 = 1'b0; bus1.op4 = 1'b0; bus1.out_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_in_ready", 32'(bus0.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        chk("rst_alu_ctrl", 32'(bus0.alu_ctrl), 32'd0);
        chk("rst_flags", 32'({bus0.illegal, bus0.multicycle, bus0.mc_start, bus0.mc_abort}), 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus0.in_ready), 32'd1);

        // Load/store and branches (last two illegal)
        issue(0, 2'b00, 3'b101, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 5'b01100, 1'b0, 1'b0, 1'b1);
        chk("no_bubble", 32'(last_wait), 32'd0);
        issue(0, 2'b01, 3'b001, 1'b0, 1'b0, 1'b0, 5'b01101, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b01, 3'b100, 1'b0, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b01, 3'b101, 1'b0, 1'b0, 1'b0, 5'b01001, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b01, 3'b110, 1'b0, 1'b0, 1'b0, 5'b01010, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b01, 3'b111, 1'b0, 1'b0, 1'b0, 5'b01011, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b1);
        chk("illegal_single_cycle", 32'({bus0.out_valid, bus0.illegal, bus0.busy}), 32'b110);
        issue(0, 2'b01, 3'b011, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b1);
        // R-type
        issue(0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b10, 3'b001, 1'b0, 1'b0, 1'b0, 5'b00110, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b10, 3'b010, 1'b0, 1'b0, 1'b0, 5'b00101, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b10, 3'b011, 1'b0, 1'b0, 1'b0, 5'b01111, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b10, 3'b100, 1'b0, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b10, 3'b101, 1'b0, 1'b0, 1'b0, 5'b00111, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 5'b01110, 1'b0, 1'b0, 1'b1);
        chk("sra_t1", 32'({bus0.out_valid, bus0.alu_ctrl, bus0.illegal}), 32'b1_01110_0);
        issue(0, 2'b10, 3'b110, 1'b0, 1'b0, 1'b0, 5'b00011, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b10, 3'b111, 1'b0, 1'b0, 1'b0, 5'b00010, 1'b0, 1'b0, 1'b1);
        // I-type
        issue(0, 2'b11, 3'b000, 1'b1, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b11, 3'b010, 1'b0, 1'b0, 1'b1, 5'b00101, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b11, 3'b010, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b11, 3'b011, 1'b0, 1'b0, 1'b1, 5'b01111, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b11, 3'b100, 1'b0, 1'b0, 1'b1, 5'b00100, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b11, 3'b110, 1'b0, 1'b0, 1'b1, 5'b00011, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b11, 3'b001, 1'b0, 1'b0, 1'b1, 5'b00110, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b11, 3'b101, 1'b0, 1'b0, 1'b1, 5'b00111, 1'b0, 1'b0, 1'b1);
        issue(0, 2'b11, 3'b101, 1'b1, 1'b0, 1'b1, 5'b01110, 1'b0, 1'b0, 1'b1);

        // MUL: start pulse at T+1, result at T+2
        issue(0, 2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 5'b10000, 1'b0, 1'b1, 1'b1);
        chk("mul_t1", 32'({bus0.mc_start, bus0.busy, bus0.out_valid}), 32'b110);
        tick();
        chk("mul_t2", 32'({bus0.mc_start, bus0.busy, bus0.out_valid}), 32'b001);
        issue(0, 2'b10, 3'b011, 1'b0, 1'b1, 1'b0, 5'b10011, 1'b0, 1'b1, 1'b1);

        // DIV: 33-cycle latency
        issue(0, 2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 5'b10100, 1'b0, 1'b1, 1'b1);
        chk("div_t1", 32'({bus0.mc_start, bus0.busy, bus0.out_valid}), 32'b110);
        bad = 0;
        for (int k = 2; k <= 32; k++) begin
            tick();
            if (bus0.mc_start !== 1'b0 || bus0.busy !== 1'b1 || bus0.out_valid !== 1'b0) bad++;
        end
        chk("div_busy_window", 32'(bad), 32'd0);
        tick();
        chk("div_t33", 32'({bus0.busy, bus0.out_valid, bus0.alu_ctrl, bus0.multicycle}), 32'b0_1_10100_1);
        issue(0, 2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 5'b10111, 1'b0, 1'b1, 1'b1);
        tick();

        // Back-pressure then simultaneous consume + accept
        issue(0, 2'b11, 3'b100, 1'b0, 1'b0, 1'b1, 5'b00100, 1'b0, 1'b0, 1'b1);
        bus0.out_ready = 1'b0;
        bus0.alu_op = 2'b11; bus0.funct3 = 3'b111; bus0.funct7_5 = 1'b0;
        bus0.funct7_0 = 1'b0; bus0.op4 = 1'b1; bus0.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_hold", 32'({bus0.in_ready, bus0.out_valid, bus0.alu_ctrl, bus0.illegal, bus0.multicycle}),
                32'b0_1_00100_0_0);
            tick();
        end
        bus0.out_ready = 1'b1;
        #1;
        chk("stall_release_ready", 32'(bus0.in_ready), 32'd1);
        q0.push_back('{ctrl: 5'b00010, ill: 1'b0, mc: 1'b0});
        tick();
        bus0.in_valid = 1'b0;
        chk("stall_next_and", 32'({bus0.out_valid, bus0.alu_ctrl}), 32'b1_00010);
        tick();
        chk("consume_clears_valid", 32'(bus0.out_valid), 32'd0);

        // Flush clears a held result
        bus0.out_ready = 1'b0;
        issue(0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
        bus0.flush = 1'b1;
        tick();
        bus0.flush = 1'b0;
        bus0.out_ready = 1'b1;
        chk("flush_clears_valid", 32'(bus0.out_valid), 32'd0);

        // Flush in the accept cycle drops the request
        bus0.alu_op = 2'b10; bus0.funct3 = 3'b000; bus0.funct7_0 = 1'b1; bus0.in_valid = 1'b1;
        bus0.flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(bus0.in_ready), 32'd0);
        tick();
        bus0.in_valid = 1'b0; bus0.flush = 1'b0;
        chk("flush_drop", 32'({bus0.out_valid, bus0.busy, bus0.mc_start}), 32'b000);

        // MUL then flush in T+1
        issue(0, 2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 5'b10000, 1'b0, 1'b1, 1'b0);
        chk("abort_t1_start", 32'(bus0.mc_start), 32'd1);
        bus0.flush = 1'b1;
        tick();
        bus0.flush = 1'b0;
        #1;
        chk("abort_t2", 32'({bus0.mc_abort, bus0.out_valid, bus0.busy, bus0.in_ready}), 32'b1001);
        tick();
        chk("abort_t3", 32'({bus0.mc_abort, bus0.out_valid}), 32'b00);

        // Reset mid-EXEC, with flush also high
        issue(0, 2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 5'b10100, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        bus0.flush = 1'b1;
        rst = 1'b0;
        tick();
        chk("rst_exec_state", 32'({bus0.busy, bus0.out_valid, bus0.mc_abort, bus0.mc_start, bus0.in_ready}),
            32'b00000);
        chk("rst_exec_regs", 32'({bus0.alu_ctrl, bus0.illegal, bus0.multicycle}), 32'd0);
        rst = 1'b1;
        bus0.flush = 1'b0;
        #1;
        chk("rst_exec_release_ready", 32'(bus0.in_ready), 32'd1);
        tick();

        // M_EN=0 instance: M-extension encodings are illegal and single-cycle
        issue(1, 2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b1);
        chk("men0_single_cycle", 32'({bus1.busy, bus1.out_valid, bus1.mc_start}), 32'b010);
        issue(1, 2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b1);
        issue(1, 2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
